// File: rtl/nand_result_fifo.sv
// nand_result_fifo
//   First-word-fall-through FIFO buffering 4-bit NAND result words between
//   the NAND gate output and a downstream consumer.
//
//   Parameters
//     WIDTH  data width in bits (default 4)
//     DEPTH  storage entries; legal values 2, 4, 8, 16 (default 4)
//
//   Ports
//     clk        rising-edge clock
//     rst_n      synchronous active-low reset
//     in_data    word from the upstream NAND output
//     in_valid   in_data valid this cycle
//     in_ready   FIFO can accept a word (count != DEPTH)
//     out_data   head-of-FIFO word; holds last value when empty
//     out_valid  out_data holds a valid word (count != 0)
//     out_ready  consumer accepts out_data this cycle
//     count      number of stored words
//     drop_cnt   saturating count of writes offered while full
//                (only when NAND_FIFO_DROP_CNT_EN is defined)
//
//   Optional feature macro: NAND_FIFO_DROP_CNT_EN
module nand_result_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
`ifdef NAND_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]               drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_next;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] head_next;
  logic             push;
  logic             pop;

  // Handshake flags depend only on registered count.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    rd_next    = pop ? rd_ptr + PW'(1) : rd_ptr;
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // out_data is a register loaded with the word that will be at the head
  // after this edge. If that slot is the one being written right now, the
  // word comes straight from in_data; when the FIFO goes empty it holds.
  always_comb begin
    head_next = out_data;
    if (count_next != '0) begin
      if (push && (rd_next == wr_ptr)) begin
        head_next = in_data;
      end else begin
        head_next = mem[rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      out_data <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr   <= rd_next;
      count    <= count_next;
      out_data <= head_next;
    end
  end

`ifdef NAND_FIFO_DROP_CNT_EN
  logic drop;
  assign drop = in_valid & ~in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nand_result_fifo.sv
// Testbench for nand_result_fifo (WIDTH=4, DEPTH=4).
// A queue-based model tracks FIFO contents; a compare process checks
// every cycle after the first reset, and directed sequences pin literals.
module tb_nand_result_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       count;
`ifdef NAND_FIFO_DROP_CNT_EN
  logic [7:0]       drop_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  nand_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
`ifdef NAND_FIFO_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_last;
  int               m_drops;
  bit               m_ok = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_last  = '0;
      m_drops = 0;
      m_ok    = 1;
    end else if (m_ok) begin
      bit do_push, do_pop;
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = out_ready && (q.size() > 0);
      if (in_valid && !do_push && m_drops < 255) m_drops++;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(in_data);
      if (q.size() > 0) m_last = q[0];
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_ok) begin
      chk("count",     32'(count),     32'(q.size()));
      chk("in_ready",  32'(in_ready),  32'(q.size() != DEPTH));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("out_data",  32'(out_data),  32'(m_last));
`ifdef NAND_FIFO_DROP_CNT_EN
      chk("drop_cnt",  32'(drop_cnt),  32'(m_drops));
`endif
    end
  end

  // Apply inputs just after a falling edge, hold across one rising edge.
  task automatic cyc(input logic r, input logic v, input logic [WIDTH-1:0] d, input logic o);
    rst_n = r; in_valid = v; in_data = d; out_ready = o;
    @(negedge clk);
  endtask

  logic [WIDTH-1:0] exp4[4];
  logic [WIDTH-1:0] got[$];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    cyc(0, 1, 4'h9, 1);
    cyc(0, 0, 4'h0, 0);
    chk("rst_count",     32'(count),     0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready",  32'(in_ready),  1);
    chk("rst_out_data",  32'(out_data),  0);
`ifdef NAND_FIFO_DROP_CNT_EN
    chk("rst_drop_cnt",  32'(drop_cnt),  0);
`endif

    // Three pushes with consumer stalled
    cyc(1, 1, 4'b1111, 0);
    chk("first_push_lat", 32'(out_valid), 1);
    cyc(1, 1, 4'b1101, 0);
    cyc(1, 1, 4'b1011, 0);
    chk("p3_count",    32'(count),    3);
    chk("p3_out_data", 32'(out_data), 4'hF);
    chk("p3_in_ready", 32'(in_ready), 1);
    chk("p3_model",    32'(q.size()), 3);

    // Fill, then a dropped write
    cyc(1, 1, 4'hF, 0);
    chk("full_count", 32'(count), 4);
    cyc(1, 1, 4'h1, 0);
    chk("drop_in_ready", 32'(in_ready), 0);
    chk("drop_count",    32'(count),    4);
`ifdef NAND_FIFO_DROP_CNT_EN
    chk("drop_cnt_1",    32'(drop_cnt), 1);
`endif
    // Pop while also offering a write: full blocks the push
    exp4[0] = 4'hF; exp4[1] = 4'hD; exp4[2] = 4'hB; exp4[3] = 4'hF;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 32'(out_data), 32'(exp4[i]));
      cyc(1, (i == 0), 4'h2, 1);
    end
    chk("drain_empty", 32'(out_valid), 0);
    chk("drain_hold",  32'(out_data),  4'hF);

    // Simultaneous push/pop at count=2
    cyc(1, 1, 4'hA, 0);
    cyc(1, 1, 4'h5, 0);
    cyc(1, 1, 4'h7, 1);
    chk("pp_count", 32'(count),    2);
    chk("pp_head",  32'(out_data), 4'h5);
    cyc(1, 0, 4'h0, 1);
    cyc(1, 0, 4'h0, 1);
    chk("pp_empty", 32'(count), 0);

    // Streaming 0..9 through, pointers wrap
    got.delete();
    for (int i = 0; i < 10; i++) begin
      if (out_valid) got.push_back(out_data);
      cyc(1, 1, WIDTH'(i), 1);
      if (count > 1) chk("stream_count_le1", 32'(count), 1);
    end
    if (out_valid) got.push_back(out_data);
    cyc(1, 0, 4'h0, 1);
    chk("stream_len", 32'(got.size()), 10);
    for (int i = 0; i < got.size(); i++) chk("stream_data", 32'(got[i]), 32'(i));

    // Flush by reset while pushing
    cyc(1, 1, 4'h3, 0);
    cyc(1, 1, 4'h4, 0);
    cyc(1, 1, 4'h8, 0);
    cyc(0, 1, 4'hC, 1);
    chk("flush_count",     32'(count),     0);
    chk("flush_out_valid", 32'(out_valid), 0);
    cyc(1, 1, 4'h6, 0);
    chk("post_flush_data", 32'(out_data), 4'h6);

    // 300 dropped writes while full
    for (int i = 0; i < 3; i++) cyc(1, 1, 4'hE, 0);
    for (int i = 0; i < 300; i++) cyc(1, 1, WIDTH'($urandom), 0);
    chk("sat_count", 32'(count), 4);
`ifdef NAND_FIFO_DROP_CNT_EN
    chk("drop_sat", 32'(drop_cnt), 8'hFF);
`endif

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0),
          WIDTH'($urandom), ($urandom_range(0, 2) != 0));
    end
    cyc(1, 0, 4'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
